slow_tick_counter: RTL
======================

Name: slow_tick_counter

Overview:
- Sits directly downstream of the divide-by-8 clock stage.
- Samples the divided clock level as a data input in the `clk` domain and turns each rising edge into a one-cycle `tick` pulse.
- Counts ticks in a modulo-(MAX+1) up/down counter with enable, clear, load and wrap signalling.
- Feeds display/timer logic without using the divided signal as a clock.

Parameters:
- WIDTH, 4, counter width in bits.
- MAX, 9, terminal count; counter range is 0..MAX. MAX must be < 2^WIDTH.

Ports:
- clk  input  1  system clock; every register updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- div_in  input  1  divided clock level. It is produced by a register clocked on `clk`, so no synchronizer is needed.
- en  input  1  run enable.
- dir  input  1  count direction: 1 = up, 0 = down.
- clr  input  1  synchronous clear of the count.
- load  input  1  synchronous load of the count.
- load_val  input  WIDTH  value used by `load`.
- tick  output  1  one-cycle pulse for each counted rising edge of `div_in`.
- count  output  WIDTH  current count.
- wrap  output  1  one-cycle pulse when count wraps (MAX->0 up, 0->MAX down).
- running  output  1  high while the FSM is in RUN.

Behaviour:
- Reset (`rst`=1 at a `clk` edge):
  - state=IDLE, count=0, tick=0, wrap=0, running=0.
  - Edge register `div_q`=1, so a `div_in` that is high at reset release is not seen as a rise.
- Edge detect:
  - `div_q` <= `div_in` every cycle.
  - rise = `div_in` & ~`div_q` (internal, combinational).
- FSM transitions:
  - IDLE: `en`=1 -> ARM. Count is held.
  - ARM: waits for the first rise. That rise is NOT counted (phase alignment); next state is RUN. `en`=0 -> IDLE.
  - RUN: each rise increments or decrements the count. `en`=0 -> PAUSE.
  - PAUSE: count is held and rises are ignored. `en`=1 -> RUN with no re-arm. `en` held 0 keeps the FSM in PAUSE.
- Latency: `tick`, `count` and `wrap` are registered. All three change in the cycle after the `clk` edge where rise=1 in RUN.
- Priority within one cycle: `rst` > `clr` > `load` > rise.
  - `clr`: count=0; tick=0, wrap=0. State is unchanged.
  - `load`: count = min(`load_val`, MAX); tick=0, wrap=0. State is unchanged.
  - A rise coinciding with `clr` or `load` is dropped, not deferred.
- Count arithmetic:
  - Up: count==MAX -> 0 with wrap=1; otherwise count+1.
  - Down: count==0 -> MAX with wrap=1; otherwise count-1.
  - No out-of-range value is ever reachable.
- `dir` is sampled only on the rise cycle. Changing `dir` between rises is legal.
- `en` falling on the same cycle as a rise in RUN: the rise is counted, then the FSM moves to PAUSE.
- `running` is registered state==RUN and is 0 in IDLE, ARM and PAUSE.
- `rst` mid-count overrides everything in the same cycle.

Decomposition:
- Package `slow_tick_pkg` contains:
  - the 2-bit state type: IDLE=2'b00, ARM=2'b01, RUN=2'b10, PAUSE=2'b11;
  - the default WIDTH and MAX constants.
- Sub-module `rise_detect` (clk, rst, d, rise) holds `div_q`, with reset value 1.
- The top level holds the FSM and the modulo counter.

Test Plan:
- Drive `div_in` from the upstream /8 stage (4 cycles high, 4 low); `en`=1, `dir`=1 after reset -> first rise only arms; later ticks come every 8 cycles; count goes 1,2,…,9,0 with wrap=1 on the 9->0 step only.
- `div_in`=1 during and after `rst` deasserts -> no tick and no ARM exit until a real 0->1 transition.
- `dir`=0 from count=0 in RUN -> next tick gives count=9 with wrap=1, then 8, 7.
- `load`=1, `load_val`=12 with MAX=9 -> count=9; `load` coincident with a rise -> count equals the loaded value and tick=0.
- `clr` and `load` asserted in the same cycle -> count=0; drop `en` in RUN -> running=0, ticks ignored, count held; raise `en` -> counting resumes on the next rise without re-arming.
- Assert `rst` at count=5 in RUN -> next cycle count=0, state=IDLE, running=0, tick=0.

Source files
------------

// File: rtl/slow_tick_pkg.sv
// -----------------------------------------------------------------------------
// slow_tick_pkg
// Shared types and default sizing for the slow_tick_counter block.
//   state_e        : 2-bit FSM state encoding (IDLE, ARM, RUN, PAUSE)
//   DEFAULT_WIDTH  : default counter width in bits
//   DEFAULT_MAX    : default terminal count (range is 0..MAX)
// -----------------------------------------------------------------------------
package slow_tick_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_MAX   = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARM   = 2'b01,
        RUN   = 2'b10,
        PAUSE = 2'b11
    } state_e;

endpackage : slow_tick_pkg

// File: rtl/rise_detect.sv
// -----------------------------------------------------------------------------
// rise_detect
// Turns a level that is already synchronous to clk into a rising-edge strobe.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   d    : level input (registered upstream in the clk domain)
//   rise : combinational strobe, high when d is 1 and was 0 last cycle
// -----------------------------------------------------------------------------
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic r_div_q;

    // Reset to 1 so a level that is already high when reset releases is not
    // mistaken for a fresh rising edge.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_q <= 1'b1;
        end else begin
            r_div_q <= d;
        end
    end

    assign rise = d & ~r_div_q;

endmodule : rise_detect

// File: rtl/slow_tick_counter.sv
// -----------------------------------------------------------------------------
// slow_tick_counter
// Samples the divided clock level as data, turns each rising edge into a
// one-cycle tick and counts ticks in a modulo-(MAX+1) up/down counter.
// Ports:
//   clk      : system clock, all registers update on its rising edge
//   rst      : synchronous, active-high reset
//   div_in   : divided clock level (already in the clk domain)
//   en       : run enable
//   dir      : count direction, 1 = up, 0 = down (sampled on rise only)
//   clr      : synchronous clear of the count
//   load     : synchronous load of the count (clamped to MAX)
//   load_val : value used by load
//   tick     : registered one-cycle pulse per counted rise
//   count    : registered current count, always within 0..MAX
//   wrap     : registered one-cycle pulse on MAX->0 (up) or 0->MAX (down)
//   running  : high while the FSM is in RUN
// -----------------------------------------------------------------------------
module slow_tick_counter
    import slow_tick_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int MAX   = DEFAULT_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_in,
    input  logic             en,
    input  logic             dir,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             running
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;
    logic             r_tick;
    logic             w_tick_next;
    logic             r_wrap;
    logic             w_wrap_next;
    logic             w_rise;
    logic             w_count_rise;

    rise_detect u_rise_detect (
        .clk  (clk),
        .rst  (rst),
        .d    (div_in),
        .rise (w_rise)
    );

    // Only rises seen while in RUN move the count; a rise that coincides
    // with clr or load is dropped rather than deferred.
    assign w_count_rise = w_rise & (r_state == RUN) & ~clr & ~load;

    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (en) w_state_next = ARM;
            // The first rise after arming only aligns phase and is not counted.
            ARM:     if (!en) w_state_next = IDLE;
                     else if (w_rise) w_state_next = RUN;
            RUN:     if (!en) w_state_next = PAUSE;
            PAUSE:   if (en) w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        w_tick_next  = 1'b0;
        w_wrap_next  = 1'b0;
        if (clr) begin
            w_count_next = '0;
        end else if (load) begin
            w_count_next = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (w_count_rise) begin
            w_tick_next = 1'b1;
            if (dir) begin
                if (r_count == MAX_V) begin
                    w_count_next = '0;
                    w_wrap_next  = 1'b1;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end else begin
                if (r_count == '0) begin
                    w_count_next = MAX_V;
                    w_wrap_next  = 1'b1;
                end else begin
                    w_count_next = r_count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_tick  <= w_tick_next;
            r_wrap  <= w_wrap_next;
        end
    end

    assign tick    = r_tick;
    assign count   = r_count;
    assign wrap    = r_wrap;
    assign running = (r_state == RUN);

endmodule : slow_tick_counter
